// File: rtl/rv32i_types.sv
// Shared RV32I core types, including the cacheline arbiter's state and round-robin encodings.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SERVE_I,
        ARB_SERVE_D
    } arb_state_t;

    typedef enum logic {
        SRC_I,
        SRC_D
    } arb_src_t;

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing the physical-memory cacheline port between icache and dcache.
// A grant is held until pmem_resp, and every grant is followed by at least one IDLE cycle.
module cache_arbiter
    import rv32i_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t state;
    arb_src_t   last;

    logic d_pend;
    assign d_pend = d_read | d_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
            last  <= SRC_D;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    // On a tie, grant whoever was not served last.
                    if (i_read && (!d_pend || last == SRC_D))
                        state <= ARB_SERVE_I;
                    else if (d_pend)
                        state <= ARB_SERVE_D;
                end
                ARB_SERVE_I: begin
                    if (pmem_resp) begin
                        state <= ARB_IDLE;
                        last  <= SRC_I;
                    end
                end
                ARB_SERVE_D: begin
                    if (pmem_resp) begin
                        state <= ARB_IDLE;
                        last  <= SRC_D;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Line data passes straight through; it only matters alongside the matching resp.
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    // Outputs are forced quiet while rst is high so an abandoned transfer never completes.
    always_comb begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        pmem_addr  = '0;
        pmem_wdata = '0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        if (!rst) begin
            unique case (state)
                ARB_SERVE_I: begin
                    pmem_read = 1'b1;
                    pmem_addr = i_addr;
                    i_resp    = pmem_resp;
                end
                ARB_SERVE_D: begin
                    pmem_read  = d_read & ~d_write;
                    pmem_write = d_write;
                    pmem_addr  = d_addr;
                    pmem_wdata = d_wdata;
                    d_resp     = pmem_resp;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == ARB_SERVE_D)
            assert (!(d_read && d_write))
            else $warning("cache_arbiter: d_read and d_write both high, serving as writeback");
    end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single physical-memory cacheline port between the instruction cache and the data cache of the pipelined RV32I core.
- Sits between the two caches and the cacheline adaptor / physical memory.
- Grants one requester at a time and holds the grant until the memory responds.
- Resolves simultaneous requests round-robin so neither pipeline stage starves.

Parameters:
- ADDR_W, 32, width of cacheline address; equals rv32i_word width.
- LINE_W, 256, cacheline data width in bits.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_read  in  1  icache line-read request; held until i_resp
- i_addr  in  ADDR_W  icache line address, 32-byte aligned
- i_rdata  out  LINE_W  line returned to icache
- i_resp  out  1  one-cycle completion pulse to icache
- d_read  in  1  dcache line-read request; held until d_resp
- d_write  in  1  dcache line-writeback request; held until d_resp
- d_addr  in  ADDR_W  dcache line address, 32-byte aligned
- d_wdata  in  LINE_W  dcache writeback line
- d_rdata  out  LINE_W  line returned to dcache
- d_resp  out  1  one-cycle completion pulse to dcache
- pmem_read  out  1  memory read request
- pmem_write  out  1  memory write request
- pmem_addr  out  ADDR_W  memory line address
- pmem_wdata  out  LINE_W  memory write line
- pmem_rdata  in  LINE_W  memory read line
- pmem_resp  in  1  memory completion pulse

Behaviour:
- Reset: one clock, synchronous, active-high.
  - State returns to IDLE.
  - The round-robin pointer `last` resets to DCACHE, so the icache wins the first tie.
  - All outputs are 0 while rst is high and in the first IDLE cycle.
- States:
  - IDLE: pmem_read, pmem_write, i_resp and d_resp are 0.
    - Only icache pending: go to SERVE_I next cycle.
    - Only dcache pending (d_read or d_write): go to SERVE_D.
    - Both pending: grant the requester not equal to `last`.
    - Grant is registered; the pmem request appears the cycle after the request is first seen in IDLE.
  - SERVE_I: pmem_read=1, pmem_write=0, pmem_addr=i_addr.
  - SERVE_D: pmem_read=d_read and not d_write, pmem_write=d_write, pmem_addr=d_addr, pmem_wdata=d_wdata.
    - If d_read and d_write are both high, the request is treated as a write. This is a protocol violation; flag it with an assertion.
  - On pmem_resp in SERVE_x:
    - x_resp=1 combinationally in the same cycle.
    - x_rdata=pmem_rdata in the same cycle.
    - `last` updates to x.
    - Next state is IDLE.
- Mandatory IDLE bubble: at least one IDLE cycle between grants.
  - This guarantees the requester has dropped its request after the resp before re-arbitration.
  - Minimum arbitration overhead is 1 cycle in front of memory latency.
- i_rdata and d_rdata are driven from pmem_rdata at all times. They are meaningful only while the matching resp is high.
- The non-granted requester sees resp=0 and waits. Its request may assert or deassert freely while waiting.
- A granted requester must hold addr, data and request until resp. Dropping the request mid-grant is illegal; the arbiter keeps the grant until pmem_resp regardless.
- A pmem_resp arriving in IDLE is ignored: no resp is forwarded and no state change occurs.
- Reset mid-transaction:
  - Abandons the grant and returns to IDLE.
  - The pmem request drops in the cycle after rst is sampled.
  - No resp is issued for the abandoned transfer.

Decomposition:
- Shared package (rv32i_types) gains:
  - `arb_state_t` enum {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D}
  - `arb_src_t` enum {SRC_I, SRC_D} for the round-robin pointer.
- Address types use rv32i_word.
- No sub-module: the state machine plus the 1-bit pointer is a single always_ff plus combinational output decode. A one-hot grant helper is not warranted.

Test Plan:
- Lone icache read: i_read=1, i_addr=0x0000_0060 at cycle 0.
  - Required: pmem_read=1 and pmem_addr=0x60 from cycle 1.
  - pmem_resp at cycle 4 with rdata=0xA5..A5: i_resp=1 and i_rdata=0xA5..A5 in cycle 4, d_resp=0, IDLE at cycle 5.
- Lone dcache writeback: d_write=1, d_addr=0x8000_0020, d_wdata=0x1234..., pmem_resp after 3 cycles.
  - Required: pmem_write=1 with matching addr/wdata, pmem_read=0, d_resp pulses exactly once.
- Tie after reset: i_read and d_read both rise at cycle 0.
  - Icache is served first.
  - After i_resp, the IDLE bubble occurs, then SERVE_D begins; the dcache is granted within 2 cycles of i_resp.
- Round-robin fairness: both requesters held continuously for 6 transactions.
  - Required grant order I,D,I,D,I,D; no requester is granted twice in a row.
- Reset mid-operation: rst=1 while in SERVE_D with pmem_write=1.
  - Required: next cycle pmem_write=0, state IDLE, no d_resp.
  - A stray pmem_resp in that IDLE cycle produces no resp.
- Illegal dual dcache request: d_read=d_write=1.
  - Required: pmem_write=1, pmem_read=0, assertion fires.
